// File: rtl/instr_mem_loader_pkg.sv
// rtl/instr_mem_loader_pkg.sv - shared states and stream constants for the instruction-memory loader
package instr_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } load_state_e;

    localparam int HDR_BYTES = 2;
    localparam int CSUM_W    = 8;

    // States in which a load is in flight and the byte stream is consumed.
    function automatic logic state_busy(input load_state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

    function automatic logic state_can_start(input load_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/instr_mem_loader_byte_to_word_packer.sv
// rtl/instr_mem_loader_byte_to_word_packer.sv - assembles little-endian bytes into 32-bit words
module byte_to_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_strobe,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0] byte_idx;

    // The next word's byte 0 lands at the edge that ends the strobe cycle,
    // so the completed word is still intact while word_valid is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx   <= 2'd0;
            word       <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
                word     <= 32'd0;
            end else if (byte_strobe) begin
                word[8*byte_idx +: 8] <= byte_in;
                byte_idx              <= byte_idx + 2'd1;
                word_valid            <= (byte_idx == 2'd3);
            end
        end
    end

    assign last_byte = (byte_idx == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream program loader writing instruction memory and gating core reset
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byteIn,
    input  logic                  byteValid,
    output logic                  byteReady,
    output logic                  imemWriteEnable,
    output logic [ADDR_WIDTH-1:0] imemAddress,
    output logic [31:0]           imemWriteData,
    output logic                  coreReset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    load_state_e state, state_nxt;

    logic                      accept;
    logic                      start_load;
    logic                      data_strobe;
    logic                      last_byte;
    logic                      last_word;
    logic                      word_valid;
    logic [31:0]               word;
    logic [7:0]                len_lo;
    logic [8*HDR_BYTES-1:0]    len_word;
    logic [ADDR_WIDTH:0]       word_total;
    logic [ADDR_WIDTH:0]       words_done;
    logic [ADDR_WIDTH-1:0]     addr_cnt;
    logic [CSUM_W-1:0]         csum;

    assign byteReady   = state_busy(state);
    assign accept      = byteValid && byteReady;
    assign start_load  = start && state_can_start(state);
    assign data_strobe = accept && (state == ST_DATA);
    assign len_word    = {byteIn, len_lo};
    assign last_word   = (words_done == word_total - 1'b1);

    byte_to_word_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start_load),
        .byte_strobe (data_strobe),
        .byte_in     (byteIn),
        .word_valid  (word_valid),
        .word        (word),
        .last_byte   (last_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept) state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if ({1'b0, len_word} > MAX_WORDS) state_nxt = ST_ERROR;
                    else if (len_word == '0)          state_nxt = ST_CHECK;
                    else                              state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_strobe && last_byte && last_word) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (accept) state_nxt = (byteIn == csum) ? ST_DONE : ST_ERROR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The address counter saturates at the top word so a full-capacity
    // program never wraps back onto word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo     <= 8'd0;
            word_total <= '0;
            words_done <= '0;
            addr_cnt   <= '0;
            csum       <= '0;
        end else if (start_load) begin
            words_done <= '0;
            addr_cnt   <= '0;
            csum       <= '0;
        end else begin
            if (accept && (state == ST_LEN_LO)) len_lo <= byteIn;
            if (accept && (state == ST_LEN_HI)) word_total <= (ADDR_WIDTH+1)'(len_word);
            if (data_strobe) begin
                csum <= csum ^ byteIn;
                if (last_byte) words_done <= words_done + 1'b1;
            end
            if (word_valid && (addr_cnt != '1)) addr_cnt <= addr_cnt + 1'b1;
        end
    end

    assign imemWriteEnable = word_valid;
    assign imemAddress     = addr_cnt;
    assign imemWriteData   = word;
    assign busy            = state_busy(state);
    assign done            = (state == ST_DONE);
    assign error           = (state == ST_ERROR);
    assign coreReset       = (state != ST_DONE);

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - randomized self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    byteIn;
    logic          byteValid;
    logic          byteReady;
    logic          imemWriteEnable;
    logic [AW-1:0] imemAddress;
    logic [31:0]   imemWriteData;
    logic          coreReset;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;
    bit bp = 1'b0;

    logic [31:0] prog[$];
    int unsigned act_addr[$];
    logic [31:0] act_data[$];

    instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .byteIn          (byteIn),
        .byteValid       (byteValid),
        .byteReady       (byteReady),
        .imemWriteEnable (imemWriteEnable),
        .imemAddress     (imemAddress),
        .imemWriteData   (imemWriteData),
        .coreReset       (coreReset),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imemWriteEnable) begin
            act_addr.push_back(int'(imemAddress));
            act_data.push_back(imemWriteData);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] prog_xor(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++) begin
            x = x ^ prog[i][7:0] ^ prog[i][15:8] ^ prog[i][23:16] ^ prog[i][31:24];
        end
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        if (bp) begin
            repeat ($urandom_range(0, 2)) begin
                byteValid = 1'b0;
                byteIn    = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        byteIn    = b;
        byteValid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (byteReady) begin
                @(posedge clk); #1;
                break;
            end
            guard++;
            if (guard > 40) begin
                check_eq("byte_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        byteValid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n_exp);
        check_eq({tag, "_wcount"}, act_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < act_addr.size(); i++) begin
            check_eq({tag, "_waddr"}, act_addr[i], i);
            check_eq({tag, "_wdata"}, act_data[i], prog[i]);
        end
    endtask

    // Expected outcome comes straight from the stream rules: oversize length
    // fails with no writes, otherwise every word lands at its index and the
    // result depends only on the data-byte XOR.
    task automatic run_load(input string tag, input int n, input logic [7:0] cs, input bit mid_start);
        bit len_bad = (n > CAP);
        bit ok      = !len_bad && (cs == prog_xor(n));
        act_addr.delete();
        act_data.delete();
        pulse_start();
        check_eq({tag, "_busy_at_start"}, busy, 1);
        check_eq({tag, "_done_at_start"}, done, 0);
        check_eq({tag, "_corerst_at_start"}, coreReset, 1);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (len_bad) begin
            check_eq({tag, "_len_error"}, error, 1);
            check_eq({tag, "_len_busy"}, busy, 0);
            check_eq({tag, "_len_corerst"}, coreReset, 1);
            repeat (3) begin @(posedge clk); #1; end
            check_eq({tag, "_len_wcount"}, act_addr.size(), 0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(prog[i][8*k +: 8]);
                if (mid_start && i == 0 && k == 2) pulse_start();
            end
        end
        send_byte(cs);
        check_eq({tag, "_done"}, done, ok);
        check_eq({tag, "_error"}, error, !ok);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_corerst"}, coreReset, !ok);
        repeat (2) begin @(posedge clk); #1; end
        check_writes(tag, n);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, byteReady, 0);
        check_eq({tag, "_we"}, imemWriteEnable, 0);
        check_eq({tag, "_addr"}, imemAddress, 0);
        check_eq({tag, "_wdata"}, imemWriteData, 0);
        check_eq({tag, "_corerst"}, coreReset, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_error"}, error, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        byteIn    = 8'h00;
        byteValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        prog = '{32'h00A00513, 32'h00B00593};
        run_load("nominal", 2, prog_xor(2), 1'b0);
        run_load("bad_csum", 2, 8'h00, 1'b0);
        bp = 1'b1;
        run_load("backpressure", 2, prog_xor(2), 1'b0);
        bp = 1'b0;

        run_load("n_zero", 0, 8'h00, 1'b0);

        prog = '{32'h11223344, 32'hDEADBEEF, 32'h00000013, 32'hFFFFFFFF};
        run_load("n_full", 4, prog_xor(4), 1'b0);

        prog = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        run_load("n_over", 5, 8'h00, 1'b0);

        prog = '{32'h00A00513, 32'h00B00593};
        run_load("mid_start", 2, prog_xor(2), 1'b1);

        act_addr.delete();
        act_data.delete();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int j = 0; j < 6; j++) send_byte(prog[j / 4][8*(j % 4) +: 8]);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_values("mid_reset");
        repeat (3) begin @(posedge clk); #1; end
        check_writes("mid_reset", 1);

        run_load("after_reset", 2, prog_xor(2), 1'b0);

        prog = '{32'h00100093};
        run_load("reload", 1, prog_xor(1), 1'b0);

        for (int t = 0; t < 12; t++) begin
            int n = $urandom_range(0, CAP + 1);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            bp = 1'($urandom);
            run_load($sformatf("rand%0d", t), n,
                     ($urandom_range(0, 3) == 0) ? (prog_xor(n) ^ 8'h5A) : prog_xor(n),
                     ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
